// File: rtl/btb_direct_mapped.sv
// Direct-mapped branch target buffer with combinational lookup, EX-stage training
// and a sequential invalidate engine. Optional macro: BTB_BYPASS_EN (update-to-lookup forwarding).
module btb_direct_mapped #(
   parameter int BTB_INDEX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   output logic        BTB_hit,
   output logic [31:0] o_target,
   input  logic        update,
   input  logic [31:0] pc_ex,
   input  logic        taken,
   input  logic [31:0] target_ex,
   input  logic        flush_req,
   output logic        busy
);

   localparam int DEPTH = 1 << BTB_INDEX;
   localparam int TAG_W = 30 - BTB_INDEX;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t               state_r;
   state_t               state_nxt_s;
   logic [BTB_INDEX-1:0] cnt_r;
   logic [BTB_INDEX-1:0] cnt_nxt_s;

   logic [DEPTH-1:0]     valid_r;
   logic [TAG_W-1:0]     tag_mem_r    [DEPTH];
   logic [29:0]          target_mem_r [DEPTH];

   logic                 wr_en_s;
   logic [BTB_INDEX-1:0] wr_idx_s;
   logic [TAG_W-1:0]     wr_tag_s;
   logic [BTB_INDEX-1:0] rd_idx_s;
   logic [TAG_W-1:0]     rd_tag_s;
   logic                 table_hit_s;
   logic                 bypass_s;
   logic                 hit_s;
   logic [31:0]          tgt_s;
   logic                 unused_s;

   assign wr_en_s  = update && taken && (pc_ex[1:0] == 2'b00) && (state_r == IDLE);
   assign wr_idx_s = pc_ex[BTB_INDEX+1:2];
   assign wr_tag_s = pc_ex[31:BTB_INDEX+2];
   assign rd_idx_s = pc_in[BTB_INDEX+1:2];
   assign rd_tag_s = pc_in[31:BTB_INDEX+2];
   assign unused_s = ^target_ex[1:0];

   // FSM state and clear counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Invalidate sequencing: walk every index once, then return to IDLE
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (flush_req) begin
               state_nxt_s = CLEAR;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = cnt_r;
            end
         end
         CLEAR: begin
            cnt_nxt_s = cnt_r + BTB_INDEX'(1);
            if (cnt_r == {BTB_INDEX{1'b1}}) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = CLEAR;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // Valid bits: async cleared; the clear engine has priority over training
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_r <= '0;
      end else if (state_r == CLEAR) begin
         valid_r[cnt_r] <= 1'b0;
      end else if (wr_en_s) begin
         valid_r[wr_idx_s] <= 1'b1;
      end
   end

   // Tag and target payload, deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         tag_mem_r[wr_idx_s]    <= wr_tag_s;
         target_mem_r[wr_idx_s] <= target_ex[31:2];
      end
   end

   // Same-cycle forwarding of a qualifying update to a matching lookup
   always_comb begin
`ifdef BTB_BYPASS_EN
      bypass_s = wr_en_s && (pc_ex == pc_in);
`else
      bypass_s = 1'b0;
`endif
   end

   // Lookup against stored table contents
   always_comb begin
      table_hit_s = (state_r == IDLE) && (pc_in[1:0] == 2'b00) &&
                    valid_r[rd_idx_s] && (tag_mem_r[rd_idx_s] == rd_tag_s);
      if (bypass_s) begin
         hit_s = 1'b1;
         tgt_s = {target_ex[31:2], 2'b00};
      end else if (table_hit_s) begin
         hit_s = 1'b1;
         tgt_s = {target_mem_r[rd_idx_s], 2'b00};
      end else begin
         hit_s = 1'b0;
         tgt_s = pc_in + 32'd4;
      end
   end

   assign BTB_hit  = hit_s;
   assign o_target = tgt_s;
   assign busy     = (state_r == CLEAR);

endmodule

// File: tb/tb_btb_direct_mapped.sv
// Self-checking bench for btb_direct_mapped: table-driven vectors through a scoreboard
// queue plus hand-written flush and reset-during-clear sequences.
module tb_btb_direct_mapped;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        BTB_hit;
   logic [31:0] o_target;
   logic        update;
   logic [31:0] pc_ex;
   logic        taken;
   logic [31:0] target_ex;
   logic        flush_req;
   logic        busy;

   int checks = 0;
   int errors = 0;

`ifdef BTB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic        upd;
      logic [31:0] pe;
      logic        tk;
      logic [31:0] te;
      logic        fl;
      logic [31:0] pi;
      logic        eh;
      logic [31:0] et;
      logic        eb;
   } vec_t;

   typedef struct {
      logic        hit;
      logic [31:0] tgt;
      logic        bsy;
      string       name;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[17];

   btb_direct_mapped #(.BTB_INDEX(8)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .BTB_hit(BTB_hit), .o_target(o_target),
      .update(update), .pc_ex(pc_ex), .taken(taken), .target_ex(target_ex),
      .flush_req(flush_req), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_front();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: no expected entry");
      end else begin
         e = sb.pop_front();
         if (BTB_hit !== e.hit || o_target !== e.tgt || busy !== e.bsy) begin
            errors++;
            $display("FAIL %s: got hit=%0b tgt=%h busy=%0b, want hit=%0b tgt=%h busy=%0b",
                     e.name, BTB_hit, o_target, busy, e.hit, e.tgt, e.bsy);
         end
      end
   endtask

   task automatic expect_now(input logic eh, input logic [31:0] et, input logic eb, input string nm);
      sb.push_back('{eh, et, eb, nm});
      check_front();
   endtask

   // Drive one cycle of inputs (just after posedge), check on the negedge.
   task automatic step(input logic upd, input logic [31:0] pe, input logic tk, input logic [31:0] te,
                       input logic fl, input logic [31:0] pi,
                       input logic eh, input logic [31:0] et, input logic eb, input string nm);
      update    = upd;
      pc_ex     = pe;
      taken     = tk;
      target_ex = te;
      flush_req = fl;
      pc_in     = pi;
      sb.push_back('{eh, et, eb, nm});
      @(negedge clk);
      check_front();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input logic [31:0] pi, input logic eh, input logic [31:0] et,
                       input logic eb, input string nm);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, pi, eh, et, eb, nm);
   endtask

   initial begin
      //          upd   pc_ex          tk    target_ex      fl    pc_in          hit   target                        busy
      tbl[0]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h100,       1'b0, 32'h104,                      1'b0};
      tbl[1]  = '{1'b1, 32'h100,       1'b1, 32'h200,       1'b0, 32'h0,         1'b0, 32'h4,                        1'b0};
      tbl[2]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h100,       1'b1, 32'h200,                      1'b0};
      tbl[3]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h500,       1'b0, 32'h504,                      1'b0};
      tbl[4]  = '{1'b1, 32'h100,       1'b0, 32'h900,       1'b0, 32'h100,       1'b1, 32'h200,                      1'b0};
      tbl[5]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h100,       1'b1, 32'h200,                      1'b0};
      tbl[6]  = '{1'b1, 32'h102,       1'b1, 32'h700,       1'b0, 32'h104,       1'b0, 32'h108,                      1'b0};
      tbl[7]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h100,       1'b1, 32'h200,                      1'b0};
      tbl[8]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h102,       1'b0, 32'h106,                      1'b0};
      tbl[9]  = '{1'b1, 32'h300,       1'b1, 32'h800,       1'b0, 32'h300,       BYP,  BYP ? 32'h800 : 32'h304,      1'b0};
      tbl[10] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h300,       1'b1, 32'h800,                      1'b0};
      tbl[11] = '{1'b1, 32'h400,       1'b1, 32'hA00,       1'b0, 32'h0,         1'b0, 32'h4,                        1'b0};
      tbl[12] = '{1'b1, 32'h400,       1'b1, 32'hB00,       1'b0, 32'h400,       1'b1, BYP ? 32'hB00 : 32'hA00,      1'b0};
      tbl[13] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h400,       1'b1, 32'hB00,                      1'b0};
      tbl[14] = '{1'b1, 32'h3FC,       1'b1, 32'h1234,      1'b0, 32'hFFFFFFFC,  1'b0, 32'h0,                        1'b0};
      tbl[15] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h3FC,       1'b1, 32'h1234,                     1'b0};
      tbl[16] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'hFFFFFFFC,  1'b0, 32'h0,                        1'b0};

      rst = 1'b0; update = 1'b0; pc_ex = 32'h0; taken = 1'b0; target_ex = 32'h0;
      flush_req = 1'b0; pc_in = 32'h100;
      #1;
      expect_now(1'b0, 32'h104, 1'b0, "reset");
      @(negedge clk);
      expect_now(1'b0, 32'h104, 1'b0, "reset_held");
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         step(tbl[i].upd, tbl[i].pe, tbl[i].tk, tbl[i].te, tbl[i].fl, tbl[i].pi,
              tbl[i].eh, tbl[i].et, tbl[i].eb, $sformatf("tbl[%0d]", i));
      end

      // Flush together with an update; updates and a repeated flush during CLEAR are ignored.
      step(1'b1, 32'h200, 1'b1, 32'h600, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, "flush_issue");
      for (int k = 0; k < 256; k++) begin
         step(1'b1, 32'h500, 1'b1, 32'h900, (k == 255), 32'h500, 1'b0, 32'h504, 1'b1,
              $sformatf("clear_cycle_%0d", k));
      end
      look(32'h100, 1'b0, 32'h104, 1'b0, "after_flush_100");
      look(32'h200, 1'b0, 32'h204, 1'b0, "after_flush_200");
      look(32'h3FC, 1'b0, 32'h400, 1'b0, "after_flush_3fc");
      look(32'h300, 1'b0, 32'h304, 1'b0, "after_flush_300");
      look(32'h500, 1'b0, 32'h504, 1'b0, "after_flush_500");
      look(32'h400, 1'b0, 32'h404, 1'b0, "after_flush_400");

      // Reset asserted at CLEAR cycle 10.
      step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h4, 1'b0, "refill_100");
      step(1'b1, 32'h3FC, 1'b1, 32'h1234, 1'b0, 32'h100, 1'b1, 32'h200, 1'b0, "refill_3fc");
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h3FC, 1'b1, 32'h1234, 1'b0, "flush2_issue");
      for (int k = 0; k < 10; k++) begin
         look(32'h100, 1'b0, 32'h104, 1'b1, $sformatf("clear2_cycle_%0d", k));
      end
      rst = 1'b0;
      #1;
      expect_now(1'b0, 32'h104, 1'b0, "rst_mid_clear");
      @(posedge clk);
      #1;
      expect_now(1'b0, 32'h104, 1'b0, "rst_mid_clear_held");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      look(32'h100, 1'b0, 32'h104, 1'b0, "post_rst_100");
      look(32'h3FC, 1'b0, 32'h400, 1'b0, "post_rst_3fc");
      look(32'h3FC, 1'b0, 32'h400, 1'b0, "post_rst_idle");
      step(1'b1, 32'h600, 1'b1, 32'h700, 1'b0, 32'h600, BYP, BYP ? 32'h700 : 32'h604, 1'b0, "post_rst_update");
      look(32'h600, 1'b1, 32'h700, 1'b0, "post_rst_hit");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btb_direct_mapped.md
# btb_direct_mapped

Direct-mapped branch target buffer in the fetch stage, directly upstream of the local branch predictor. It looks up the fetch PC combinationally and drives `BTB_hit`, which gates the local direction predictor, and the predicted target to the PC-select mux. It is trained from the EX stage with the same `update` / `pc_ex` / `taken` strobe that trains the predictor. It also has a sequential invalidate engine for `fence.i` / context switch.

## Interface
Parameters:
- `BTB_INDEX`, 8: index width; the table holds 2**BTB_INDEX entries, indexed by `pc[BTB_INDEX+1:2]`.
- Tag width is derived, not a parameter: 30-BTB_INDEX bits, taken from `pc[31:BTB_INDEX+2]`.

Ports:
- `clk` in 1: single clock, posedge.
- `rst` in 1: asynchronous, active-low reset.
- `pc_in` in 32: fetch PC to look up.
- `BTB_hit` out 1: valid entry matches `pc_in`.
- `o_target` out 32: predicted target on hit, otherwise `pc_in+4`.
- `update` in 1: branch or jump resolved in EX this cycle.
- `pc_ex` in 32: PC of the resolved branch.
- `taken` in 1: resolved direction.
- `target_ex` in 32: resolved target address.
- `flush_req` in 1: single-cycle request to invalidate all entries.
- `busy` out 1: invalidate engine is running.

## Operation
- Storage per entry: `valid` (1 bit), `tag`, `target[31:2]`. `target[1:0]` always reads as 00.
- Lookup (combinational):
  - `BTB_hit` = state==IDLE && `pc_in[1:0]`==00 && `valid[idx]` && `tag[idx]`==`pc_in[31:BTB_INDEX+2]`.
  - `o_target` = `BTB_hit` ? `{target[idx],2'b00}` : `pc_in+4` (32-bit, wraps modulo 2**32).
- Update condition: `update` && `taken` && `pc_ex[1:0]`==00 && state==IDLE.
  - When met: write `valid`=1, tag and target at `pc_ex`'s index, overwriting any prior occupant (no replacement policy).
  - `update` with `taken`=0 leaves the table unchanged. No allocation and no eviction; direction is the local predictor's job.
- Invalidate FSM, states IDLE and CLEAR:
  - IDLE, `flush_req`=1: go to CLEAR, clear counter =0.
  - CLEAR: each cycle `valid[counter]`<=0, counter+1. On counter==2**BTB_INDEX-1, clear that entry and return to IDLE.
  - `busy`=1 exactly while in CLEAR.
  - In CLEAR: `BTB_hit` forced 0, `update` writes dropped, `flush_req` ignored.
- Reset: all `valid` cleared asynchronously, state IDLE, counter 0. Tags and targets are not reset.

## Timing
- Lookup latency is 0 cycles. A write at posedge N is visible to lookup in cycle N+1.
- Output values during and after reset:
  - `BTB_hit`=0, `busy`=0.
  - `o_target`=`pc_in+4`.
- Invalidate takes exactly 2**BTB_INDEX cycles (256 by default):
  - `busy` rises the cycle after `flush_req` is sampled.
  - `busy` falls after the last entry is cleared.
- `update` and `flush_req` in the same IDLE cycle: the write happens, then CLEAR invalidates it. Net result: all invalid.
- Reset asserted mid-CLEAR: FSM returns to IDLE immediately, all entries invalid, no resumption after release.
- Two updates to the same index on consecutive cycles: last write wins.

## Configuration
- `BTB_BYPASS_EN` defined: update-to-lookup forwarding.
  - Applies when an update condition is met this cycle and `pc_ex`==`pc_in`.
  - `BTB_hit`=1 and `o_target`=`{target_ex[31:2],2'b00}` in the same cycle, before the write lands.
  - Forwarding is suppressed in CLEAR.
- `BTB_BYPASS_EN` undefined: no forwarding. Same-cycle lookup sees the pre-write table contents.

## Test plan
- Reset, `pc_in`=0x100 → `BTB_hit`=0, `o_target`=0x104, `busy`=0.
- Update with `pc_ex`=0x100, `taken`=1, `target_ex`=0x200; next cycle `pc_in`=0x100 → `BTB_hit`=1, `o_target`=0x200. Then `pc_in`=0x500 (same index 0x40, different tag) → `BTB_hit`=0, `o_target`=0x504.
- Trained entry 0x100, then update `pc_ex`=0x100 with `taken`=0 → entry kept, `BTB_hit`=1. Update with `pc_ex`=0x102 and `taken`=1 → ignored.
- Fill entries 0x100 and 0x3FC, pulse `flush_req` → `busy` high for 256 cycles. Updates issued during CLEAR are dropped. Afterwards both lookups miss.
- `rst` low at CLEAR cycle 10 → `busy`=0 immediately. After release, all lookups miss and the FSM is in IDLE.
- With `BTB_BYPASS_EN`: update `pc_ex`=`pc_in`=0x300, `target_ex`=0x800 in the same cycle → `BTB_hit`=1, `o_target`=0x800 that cycle. Without the macro: `BTB_hit`=0 that cycle and 1 the next.
